// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU activation-memory write path.
// Latency: none (types, constants and a pure function only).
// Backpressure: n/a.
`ifndef NPU_ACT_DATA_WIDTH
`define NPU_ACT_DATA_WIDTH 16
`endif

package npu_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACTIVE, ARB_FLUSH} arb_state_e;

    localparam int NPU_NUM_MAC    = 32;
    localparam int NPU_SLICE_MAXW = 32;

    // Lane-i slice of a per-lane packed bus (lane i at [i*width +: width]).
    // The bus is presented zero-extended to the widest supported layout and
    // the result is returned right-aligned, zero-filled above 'width'.
    function automatic logic [NPU_SLICE_MAXW-1:0] lane_slice(
        input logic [NPU_NUM_MAC*NPU_SLICE_MAXW-1:0] bus,
        input int unsigned                           lane,
        input int unsigned                           width
    );
        logic [NPU_SLICE_MAXW-1:0] mask;
        mask = (width >= NPU_SLICE_MAXW) ? '1 : ((32'd1 << width) - 32'd1);
        return NPU_SLICE_MAXW'(bus >> (lane * width)) & mask;
    endfunction

endpackage

// File: rtl/npu_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping at N-1.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module npu_rr_pick #(
    parameter int N     = 32,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] rot_idx;
    logic [IDX_W:0]   idx_sum;

    // Doubling the vector turns the wrap-around search into a plain shift.
    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> ptr);

    // Lowest set bit of the rotated vector is the first lane at/after ptr.
    always_comb begin
        grant_vld = 1'b0;
        rot_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_vld = 1'b1;
                rot_idx   = IDX_W'(k);
            end
        end
    end

    // Undo the rotation (mod N) and build the one-hot grant.
    always_comb begin
        idx_sum = {1'b0, ptr} + {1'b0, rot_idx};
        if (idx_sum >= (IDX_W+1)'(N)) begin
            idx_sum = idx_sum - (IDX_W+1)'(N);
        end
        grant_idx = idx_sum[IDX_W-1:0];
        grant     = '0;
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/npu_act_wr_arbiter.sv
// Round-robin arbiter sharing the activation-memory write port among MAC lanes; optional stats via NPU_ACT_WR_ARB_STATS_EN.
// Latency: 1 cycle from pick to mem_wr_en/addr/data and the one-hot ack pulse.
// Backpressure: lanes hold req/addr/data until acked; an acked lane is masked for its ack cycle.
module npu_act_wr_arbiter
    import npu_pkg::*;
#(
    parameter int NUM_REQ    = NPU_NUM_MAC,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = `NPU_ACT_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            hw_mem_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] hw_mem_wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] hw_mem_wr_data,
    output logic [NUM_REQ-1:0]            hw_mem_wr_ack_p,
    input  logic                          layer_start_p,
    input  logic                          flush_req_p,
    output logic                          flush_done_p,
    output logic                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    output logic                          arb_busy,
    output logic [15:0]                   conflict_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e             state;
    arb_state_e             state_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]     last_grant_vec;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic [IDX_W-1:0]       next_ptr;
    logic [ADDR_WIDTH-1:0]  pick_addr;
    logic [DATA_WIDTH-1:0]  pick_data;
    logic                   any_req;
    logic                   drained;

    // A lane in its ack cycle still shows its old request; mask it.
    assign eligible = hw_mem_wr & ~last_grant_vec;
    assign any_req  = |hw_mem_wr;
    assign drained  = !any_req && !mem_wr_en;
    assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    assign hw_mem_wr_ack_p = last_grant_vec;
    assign flush_done_p    = (state == ARB_FLUSH) && drained;
    assign arb_busy        = (state != ARB_IDLE) || any_req;

    npu_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // One-hot AND-OR mux of the picked lane's address and data.
    always_comb begin
        pick_addr = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_addr = hw_mem_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_data = hw_mem_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Issue stage: register the pick; addr/data hold when nothing is picked.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_en      <= 1'b0;
            last_grant_vec <= '0;
            mem_wr_addr    <= '0;
            mem_wr_data    <= '0;
        end else begin
            mem_wr_en      <= pick_vld;
            last_grant_vec <= pick_grant;
            if (pick_vld) begin
                mem_wr_addr <= pick_addr;
                mem_wr_data <= pick_data;
            end
        end
    end

    // Pointer moves past the granted lane; a new layer restarts at lane 0.
    always_ff @(posedge clk) begin
        if (rst || layer_start_p) begin
            rr_ptr <= '0;
        end else if (pick_vld) begin
            rr_ptr <= next_ptr;
        end
    end

    // Control state: a flush request is taken from IDLE/ACTIVE only.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (flush_req_p)  state_nxt = ARB_FLUSH;
                else if (any_req) state_nxt = ARB_ACTIVE;
            end
            ARB_ACTIVE: begin
                if (flush_req_p)  state_nxt = ARB_FLUSH;
                else if (drained) state_nxt = ARB_IDLE;
            end
            ARB_FLUSH: begin
                if (drained)      state_nxt = ARB_IDLE;
            end
            default:              state_nxt = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

`ifdef NPU_ACT_WR_ARB_STATS_EN
    logic        conflict;
    logic [15:0] conflict_q;

    // Two or more eligible lanes <=> clearing the lowest set bit leaves one.
    assign conflict = |(eligible & (eligible - NUM_REQ'(1)));

    // Saturating conflict-cycle counter, cleared at each layer start.
    always_ff @(posedge clk) begin
        if (rst || layer_start_p) begin
            conflict_q <= '0;
        end else if (conflict && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_npu_act_wr_arbiter.sv
// Directed bench for npu_act_wr_arbiter with hand-computed expectations.
// Latency: expects acks/writes one cycle after the request is presented.
// Backpressure: lanes modelled by hand, holding req through their ack cycle.
module tb_npu_act_wr_arbiter;

    localparam int N  = 32;
    localparam int AW = 12;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    hw_mem_wr;
    logic [N*AW-1:0] hw_mem_wr_addr;
    logic [N*DW-1:0] hw_mem_wr_data;
    logic [N-1:0]    hw_mem_wr_ack_p;
    logic            layer_start_p;
    logic            flush_req_p;
    logic            flush_done_p;
    logic            mem_wr_en;
    logic [AW-1:0]   mem_wr_addr;
    logic [DW-1:0]   mem_wr_data;
    logic            arb_busy;
    logic [15:0]     conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    npu_act_wr_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hw_mem_wr       (hw_mem_wr),
        .hw_mem_wr_addr  (hw_mem_wr_addr),
        .hw_mem_wr_data  (hw_mem_wr_data),
        .hw_mem_wr_ack_p (hw_mem_wr_ack_p),
        .layer_start_p   (layer_start_p),
        .flush_req_p     (flush_req_p),
        .flush_done_p    (flush_done_p),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_addr     (mem_wr_addr),
        .mem_wr_data     (mem_wr_data),
        .arb_busy        (arb_busy),
        .conflict_cnt    (conflict_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane_bit(input int i);
        return 64'd1 << i;
    endfunction

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [N];
        int last[N];
        int max_gap;
        logic [63:0] exp_ack;

        rst = 1'b1;
        hw_mem_wr = '0;
        layer_start_p = 1'b0;
        flush_req_p = 1'b0;
        for (int i = 0; i < N; i++) begin
            hw_mem_wr_addr[i*AW +: AW] = 12'hA00 + 12'(i);
            hw_mem_wr_data[i*DW +: DW] = 16'hC000 + 16'(i);
        end
        hw_mem_wr_addr[5*AW +: AW] = 12'h123;
        hw_mem_wr_data[5*DW +: DW] = 16'h00AB;

        // ---- reset state ----
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_ack",   hw_mem_wr_ack_p, 0);
        chk("rst_addr",  mem_wr_addr, 0);
        chk("rst_data",  mem_wr_data, 0);
        chk("rst_busy",  arb_busy, 0);
        chk("rst_done",  flush_done_p, 0);
        chk("rst_cnt",   conflict_cnt, 0);

        // ---- single lane 5 ----
        hw_mem_wr = 32'h0000_0020;
        settle();
        chk("l5_busy", arb_busy, 1);
        chk("l5_no_ack_yet", hw_mem_wr_ack_p, 0);
        tick();
        chk("l5_wr_en", mem_wr_en, 1);
        chk("l5_ack",   hw_mem_wr_ack_p, lane_bit(5));
        chk("l5_addr",  mem_wr_addr, 64'h123);
        chk("l5_data",  mem_wr_data, 64'h00AB);
        tick();
        chk("l5_no_dbl_ack", hw_mem_wr_ack_p, 0);
        chk("l5_wr_en_off",  mem_wr_en, 0);
        chk("l5_addr_hold",  mem_wr_addr, 64'h123);
        chk("l5_data_hold",  mem_wr_data, 64'h00AB);
        hw_mem_wr = '0;
        tick();
        chk("l5_ack_idle", hw_mem_wr_ack_p, 0);
        chk("l5_busy_off", arb_busy, 0);

        // ---- lanes 0,3,31 from pointer 0 ----
        layer_start_p = 1'b1;
        tick();
        layer_start_p = 1'b0;
        hw_mem_wr = 32'h8000_0009;
        tick();
        chk("rr_g0",      hw_mem_wr_ack_p, lane_bit(0));
        chk("rr_g0_addr", mem_wr_addr, 64'hA00);
        chk("rr_g0_data", mem_wr_data, 64'hC000);
        tick();
        chk("rr_g3", hw_mem_wr_ack_p, lane_bit(3));
        hw_mem_wr = 32'h8000_0008;
        tick();
        chk("rr_g31",      hw_mem_wr_ack_p, lane_bit(31));
        chk("rr_g31_addr", mem_wr_addr, 64'hA1F);
        chk("rr_g31_data", mem_wr_data, 64'hC01F);
        hw_mem_wr = 32'h8000_0000;
        tick();
        chk("rr_quiet", hw_mem_wr_ack_p, 0);
        // Pointer wrapped to 0: lane 1 must win over lane 30.
        hw_mem_wr = 32'h4000_0002;
        tick();
        chk("rr_ptr_wrap", hw_mem_wr_ack_p, lane_bit(1));
        tick();
        chk("rr_g30", hw_mem_wr_ack_p, lane_bit(30));
        hw_mem_wr = 32'h4000_0000;
        tick();
        hw_mem_wr = '0;
        tick();

        // ---- all 32 lanes held for 64 cycles ----
        layer_start_p = 1'b1;
        tick();
        layer_start_p = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt[i]  = 0;
            last[i] = -1;
        end
        max_gap = 0;
        hw_mem_wr = '1;
        for (int c = 0; c < 64; c++) begin
            tick();
            exp_ack = lane_bit(c % 32);
            chk("all_ack", hw_mem_wr_ack_p, exp_ack);
            for (int i = 0; i < N; i++) begin
                if (hw_mem_wr_ack_p[i]) begin
                    cnt[i]++;
                    if (last[i] >= 0 && (c - last[i]) > max_gap) max_gap = c - last[i];
                    last[i] = c;
                end
            end
        end
        for (int i = 0; i < N; i++) chk("all_cnt", 64'(cnt[i]), 2);
        chk("all_max_gap", 64'(max_gap), 32);
`ifdef NPU_ACT_WR_ARB_STATS_EN
        chk("all_conflicts", conflict_cnt, 64);
`else
        chk("all_conflicts", conflict_cnt, 0);
`endif
        hw_mem_wr = '0;
        tick();
        tick();

        // ---- flush with lanes 2,7 pending ----
        hw_mem_wr = 32'h0000_0084;
        flush_req_p = 1'b1;
        settle();
        chk("fl_done_c0", flush_done_p, 0);
        tick();
        chk("fl_g2", hw_mem_wr_ack_p, lane_bit(2));
        settle();
        chk("fl_done_c1", flush_done_p, 0);
        tick();
        flush_req_p = 1'b0;
        chk("fl_g7", hw_mem_wr_ack_p, lane_bit(7));
        hw_mem_wr = 32'h0000_0080;
        settle();
        chk("fl_done_c2", flush_done_p, 0);
        tick();
        chk("fl_wr_en_off", mem_wr_en, 0);
        hw_mem_wr = '0;
        settle();
        chk("fl_done_pulse", flush_done_p, 1);
        tick();
        settle();
        chk("fl_done_once", flush_done_p, 0);
        chk("fl_busy_off",  arb_busy, 0);
        // Flush from IDLE with nothing pending.
        flush_req_p = 1'b1;
        settle();
        chk("fli_done_c0", flush_done_p, 0);
        tick();
        flush_req_p = 1'b0;
        settle();
        chk("fli_done_pulse", flush_done_p, 1);
        tick();
        chk("fli_done_once", flush_done_p, 0);

        // ---- layer_start concurrent with grant to lane 9 at pointer 10 ----
        hw_mem_wr = 32'h0000_0200;
        tick();
        chk("ls_pre_g9", hw_mem_wr_ack_p, lane_bit(9));
        tick();
        hw_mem_wr = '0;
        tick();
        hw_mem_wr = 32'h0000_0200;
        layer_start_p = 1'b1;
        tick();
        chk("ls_g9", hw_mem_wr_ack_p, lane_bit(9));
        layer_start_p = 1'b0;
        hw_mem_wr = 32'h0010_0202;
        tick();
        chk("ls_from0", hw_mem_wr_ack_p, lane_bit(1));
        hw_mem_wr = 32'h0010_0002;
        tick();
        chk("ls_g20", hw_mem_wr_ack_p, lane_bit(20));
        hw_mem_wr = 32'h0010_0000;
        tick();
        hw_mem_wr = '0;
        tick();
        tick();

        // ---- reset while a write is being picked ----
        hw_mem_wr = 32'h0000_0030;
        rst = 1'b1;
        tick();
        chk("rm_wr_en", mem_wr_en, 0);
        chk("rm_ack",   hw_mem_wr_ack_p, 0);
        rst = 1'b0;
        tick();
        chk("rm_g4", hw_mem_wr_ack_p, lane_bit(4));
        tick();
        chk("rm_g5", hw_mem_wr_ack_p, lane_bit(5));
        hw_mem_wr = 32'h0000_0020;
        tick();
        hw_mem_wr = '0;
        tick();
        tick();

`ifdef NPU_ACT_WR_ARB_STATS_EN
        // ---- conflict statistics ----
        layer_start_p = 1'b1;
        tick();
        layer_start_p = 1'b0;
        chk("st_clear0", conflict_cnt, 0);
        hw_mem_wr = 32'h0000_0006;
        repeat (4) tick();
        chk("st_two_lanes", conflict_cnt, 1);
        layer_start_p = 1'b1;
        tick();
        layer_start_p = 1'b0;
        chk("st_clear", conflict_cnt, 0);
        hw_mem_wr = 32'h0000_000E;
        repeat (65534) tick();
        chk("st_fffe", conflict_cnt, 64'hFFFE);
        tick();
        chk("st_ffff", conflict_cnt, 64'hFFFF);
        repeat (3) tick();
        chk("st_sat", conflict_cnt, 64'hFFFF);
        hw_mem_wr = '0;
        tick();
`else
        chk("st_tied0", conflict_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
